// File: rtl/audio_rom_arbiter.sv
// Purpose : round-robin share of the single SDRAM ROM read port between the
//           sound-side fetch requesters, with a one-word hit register per port.
// Latency : hit acks one edge after the request is seen in IDLE; a miss issues
//           sdr_req one edge after the request and acks on the edge the SDRAM
//           ack matches. Backpressure: toggle req/ack handshakes; a port stays
//           pending (and simply waits) while another port's fetch is in flight.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   flush             clears every hit register while high (ROM download)
//   port_req/ack      per-port request/ack toggles; pending while they differ
//   port_addr         flattened per-port byte addresses, ADDR_W bits each
//   port_data         flattened per-port returned words, 16 bits each
//   sdr_address       word-aligned byte address to SDRAM (bit 0 always 0)
//   sdr_req/ack       SDRAM toggle handshake; done when sdr_ack == sdr_req
//   sdr_data          SDRAM read word, valid when the handshake completes
module audio_rom_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 27
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_PORTS-1:0]      port_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  output logic [NUM_PORTS-1:0]      port_ack,
  output logic [NUM_PORTS*16-1:0]   port_data,
  output logic [ADDR_W-1:0]         sdr_address,
  output logic                      sdr_req,
  input  logic                      sdr_ack,
  input  logic [15:0]               sdr_data
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int WA = ADDR_W - 1;

  typedef logic [PW-1:0] port_idx_t;
  typedef logic [WA-1:0] word_addr_t;
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state_q, state_d;
  port_idx_t               rr_q, rr_d;
  port_idx_t               grant_q, grant_d;
  logic [NUM_PORTS-1:0]    ack_q, ack_d;
  logic [NUM_PORTS*16-1:0] data_q, data_d;
  logic [NUM_PORTS-1:0]    hit_valid_q, hit_valid_d;
  word_addr_t              hit_addr_q [NUM_PORTS];
  word_addr_t              hit_addr_d [NUM_PORTS];
  word_addr_t              sdr_waddr_q, sdr_waddr_d;
  logic                    sdr_req_q, sdr_req_d;

  // Per-port word address; byte lane selection is left to the requester.
  word_addr_t              req_waddr [NUM_PORTS];
  logic [NUM_PORTS-1:0]    req_lsb;
  logic [NUM_PORTS-1:0]    pending;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign req_waddr[gi] = port_addr[gi*ADDR_W+1 +: WA];
    assign req_lsb[gi]   = port_addr[gi*ADDR_W];
  end

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_lsb;

  assign pending = port_req ^ ack_q;

  function automatic port_idx_t rr_next(input port_idx_t g);
    if (g == port_idx_t'(NUM_PORTS - 1)) begin
      return '0;
    end
    return g + port_idx_t'(1);
  endfunction

  // First pending port at or after rr_q, wrapping modulo NUM_PORTS
  // (index arithmetic done in int so non-power-of-2 counts wrap correctly).
  logic      pick_vld;
  port_idx_t pick;
  int        idx;

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end
      if (!pick_vld && pending[port_idx_t'(idx)]) begin
        pick_vld = 1'b1;
        pick     = port_idx_t'(idx);
      end
    end
  end

  // flush overrides a hit so nothing stale is returned during ROM download.
  logic pick_hit;
  assign pick_hit = hit_valid_q[pick] && (hit_addr_q[pick] == req_waddr[pick]) && !flush;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    ack_d       = ack_q;
    data_d      = data_q;
    hit_valid_d = flush ? '0 : hit_valid_q;
    hit_addr_d  = hit_addr_q;
    sdr_waddr_d = sdr_waddr_q;
    sdr_req_d   = sdr_req_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          if (pick_hit) begin
            ack_d[pick] = ~ack_q[pick];
            rr_d        = rr_next(pick);
          end else begin
            sdr_waddr_d = req_waddr[pick];
            sdr_req_d   = ~sdr_req_q;
            grant_d     = pick;
            state_d     = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // New requests are ignored here; they stay pending for the next IDLE.
        // A flush during the fetch still delivers the data but leaves the
        // hit register invalid.
        if (sdr_ack == sdr_req_q) begin
          data_d[grant_q*16 +: 16] = sdr_data;
          ack_d[grant_q]           = ~ack_q[grant_q];
          hit_addr_d[grant_q]      = sdr_waddr_q;
          hit_valid_d[grant_q]     = ~flush;
          rr_d                     = rr_next(grant_q);
          state_d                  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset abandons any fetch in flight; the SDRAM controller shares this
  // reset so sdr_req = 0 stays consistent with its ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      data_q      <= '0;
      hit_valid_q <= '0;
      sdr_waddr_q <= '0;
      sdr_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      data_q      <= data_d;
      hit_valid_q <= hit_valid_d;
      sdr_waddr_q <= sdr_waddr_d;
      sdr_req_q   <= sdr_req_d;
    end
  end

  // Hit addresses are qualified by hit_valid, so they need no reset.
  always_ff @(posedge clk) begin
    hit_addr_q <= hit_addr_d;
  end

  assign port_ack    = ack_q;
  assign port_data   = data_q;
  assign sdr_address = {sdr_waddr_q, 1'b0};
  assign sdr_req     = sdr_req_q;

endmodule

// File: tb/tb_audio_rom_arbiter.sv
module tb_audio_rom_arbiter;

  localparam int NP = 4;
  localparam int AW = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              flush;
  logic [NP-1:0]     port_req;
  logic [NP*AW-1:0]  port_addr;
  logic [NP-1:0]     port_ack;
  logic [NP*16-1:0]  port_data;
  logic [AW-1:0]     sdr_address;
  logic              sdr_req;
  logic              sdr_ack;
  logic [15:0]       sdr_data;

  // Second instance with a non-power-of-2 port count.
  logic [2:0]        req3;
  logic [3*AW-1:0]   addr3;
  logic [2:0]        ack3;
  logic [47:0]       data3;
  logic [AW-1:0]     sdr_address3;
  logic              sdr_req3;
  logic              sdr_ack3;
  logic [15:0]       sdr_data3;

  audio_rom_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .port_req(port_req), .port_addr(port_addr),
    .port_ack(port_ack), .port_data(port_data),
    .sdr_address(sdr_address), .sdr_req(sdr_req),
    .sdr_ack(sdr_ack), .sdr_data(sdr_data)
  );

  audio_rom_arbiter #(.NUM_PORTS(3), .ADDR_W(AW)) u_dut3 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .port_req(req3), .port_addr(addr3),
    .port_ack(ack3), .port_data(data3),
    .sdr_address(sdr_address3), .sdr_req(sdr_req3),
    .sdr_ack(sdr_ack3), .sdr_data(sdr_data3)
  );

  // Trivial SDRAM for the 3-port instance: acks one cycle after the request,
  // data is the word address.
  always @(posedge clk) begin
    if (reset) sdr_ack3 <= 1'b0;
    else       sdr_ack3 <= sdr_req3;
  end
  assign sdr_data3 = sdr_address3[16:1];

  int   checks = 0;
  int   errors = 0;
  int   sdr_toggles = 0;
  logic sdr_req_prev = 1'b0;

  always @(negedge clk) begin
    if (sdr_req !== sdr_req_prev) sdr_toggles++;
    sdr_req_prev = sdr_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for an SDRAM request, note its address, answer after lat cycles.
  task automatic sdr_serve(input int lat, input logic [15:0] word, input bit hold_flush,
                           output logic [AW-1:0] addr, output bit ok);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sdr_req !== sdr_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      addr = sdr_address;
      if (hold_flush) flush = 1'b1;
      repeat (lat) tick();
      sdr_data = word;
      sdr_ack  = sdr_req;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (port_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", port_ack); end
    checks++; if (port_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", port_data); end
    checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL reset_sdr_req: got %b want 0", sdr_req); end
    checks++; if (sdr_address !== '0) begin errors++; $display("FAIL reset_sdr_addr: got %h want 0", sdr_address); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_miss();
    logic [AW-1:0] a;
    bit ok;
    port_addr[1*AW +: AW] = 27'h0100003;
    port_req[1] = ~port_req[1];
    sdr_serve(5, 16'hBEEF, 1'b0, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL miss_issue: got no sdr_req toggle want one"); end
    checks++; if (a !== 27'h0100002) begin errors++; $display("FAIL miss_addr: got %h want 0100002", a); end
    tick();
    checks++; if (port_ack !== 4'b0010) begin errors++; $display("FAIL miss_ack: got %b want 0010", port_ack); end
    checks++; if (port_data[16 +: 16] !== 16'hBEEF) begin errors++; $display("FAIL miss_data: got %h want beef", port_data[16 +: 16]); end
    checks++; if ({port_data[63:32], port_data[15:0]} !== 48'h0) begin
      errors++; $display("FAIL miss_other_data: got %h want 0", {port_data[63:32], port_data[15:0]});
    end
  endtask

  task automatic test_hit();
    int   t0;
    logic sr;
    t0 = sdr_toggles;
    sr = sdr_req;
    port_addr[1*AW +: AW] = 27'h0100002;
    port_req[1] = ~port_req[1];
    tick();
    checks++; if (port_ack !== 4'b0000) begin errors++; $display("FAIL hit_ack: got %b want 0000", port_ack); end
    checks++; if (sdr_req !== sr) begin errors++; $display("FAIL hit_sdr_req: got %b want %b", sdr_req, sr); end
    checks++; if (port_data[16 +: 16] !== 16'hBEEF) begin errors++; $display("FAIL hit_data: got %h want beef", port_data[16 +: 16]); end
    @(negedge clk);
    checks++; if (sdr_toggles !== t0) begin errors++; $display("FAIL hit_toggles: got %0d want %0d", sdr_toggles, t0); end
  endtask

  task automatic test_flush();
    logic [AW-1:0] a;
    bit ok;
    int t0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    t0 = sdr_toggles;
    port_req[1] = ~port_req[1];
    sdr_serve(2, 16'hCAFE, 1'b0, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_miss: got hit want sdr request"); end
    checks++; if (a !== 27'h0100002) begin errors++; $display("FAIL flush_addr: got %h want 0100002", a); end
    tick();
    checks++; if (port_ack !== 4'b0010) begin errors++; $display("FAIL flush_ack: got %b want 0010", port_ack); end
    checks++; if (port_data[16 +: 16] !== 16'hCAFE) begin errors++; $display("FAIL flush_data: got %h want cafe", port_data[16 +: 16]); end
    @(negedge clk);
    checks++; if (sdr_toggles !== t0 + 1) begin errors++; $display("FAIL flush_toggles: got %0d want %0d", sdr_toggles, t0 + 1); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a0, a1, a2;
    bit ok0, ok1, ok2;
    int t0;
    tick();
    t0 = sdr_toggles;
    port_addr[0*AW +: AW] = 27'h0000010;
    port_addr[2*AW +: AW] = 27'h0000020;
    port_addr[3*AW +: AW] = 27'h0000031;
    port_req = port_req ^ 4'b1101;
    sdr_serve(1, 16'h2222, 1'b0, a0, ok0);
    sdr_serve(1, 16'h3333, 1'b0, a1, ok1);
    sdr_serve(1, 16'h1111, 1'b0, a2, ok2);
    checks++; if (!(ok0 && ok1 && ok2)) begin errors++; $display("FAIL rr_issue: got %b%b%b want 111", ok0, ok1, ok2); end
    checks++; if (a0 !== 27'h0000020) begin errors++; $display("FAIL rr_first: got %h want 0000020", a0); end
    checks++; if (a1 !== 27'h0000030) begin errors++; $display("FAIL rr_second: got %h want 0000030", a1); end
    checks++; if (a2 !== 27'h0000010) begin errors++; $display("FAIL rr_third: got %h want 0000010", a2); end
    tick();
    checks++; if (port_ack !== 4'b1111) begin errors++; $display("FAIL rr_ack: got %b want 1111", port_ack); end
    checks++; if (port_data !== 64'h3333_2222_CAFE_1111) begin errors++; $display("FAIL rr_data: got %h want 33332222cafe1111", port_data); end
    @(negedge clk);
    checks++; if (sdr_toggles !== t0 + 3) begin errors++; $display("FAIL rr_toggles: got %0d want %0d", sdr_toggles, t0 + 3); end
  endtask

  task automatic test_flush_in_wait();
    logic [AW-1:0] a;
    bit ok;
    tick();
    port_addr[2*AW +: AW] = 27'h0000040;
    port_req[2] = ~port_req[2];
    sdr_serve(3, 16'h4444, 1'b1, a, ok);
    tick();
    flush = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL fw_issue: got no sdr_req toggle want one"); end
    checks++; if (port_ack !== 4'b1011) begin errors++; $display("FAIL fw_ack: got %b want 1011", port_ack); end
    checks++; if (port_data[32 +: 16] !== 16'h4444) begin errors++; $display("FAIL fw_data: got %h want 4444", port_data[32 +: 16]); end
    port_req[2] = ~port_req[2];
    sdr_serve(2, 16'h5555, 1'b0, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fw_rereq_miss: got hit want sdr request"); end
    checks++; if (a !== 27'h0000040) begin errors++; $display("FAIL fw_rereq_addr: got %h want 0000040", a); end
    tick();
    checks++; if (port_ack !== 4'b1111) begin errors++; $display("FAIL fw_rereq_ack: got %b want 1111", port_ack); end
    checks++; if (port_data[32 +: 16] !== 16'h5555) begin errors++; $display("FAIL fw_rereq_data: got %h want 5555", port_data[32 +: 16]); end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    seen = 1'b0;
    port_addr[3*AW +: AW] = 27'h0000050;
    port_req[3] = ~port_req[3];
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sdr_req !== sdr_ack) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmw_issue: got no sdr_req toggle want one"); end
    checks++; if (sdr_address !== 27'h0000050) begin errors++; $display("FAIL rmw_addr: got %h want 0000050", sdr_address); end
    reset    = 1'b1;
    sdr_ack  = 1'b0;
    port_req = '0;
    tick();
    checks++; if (port_ack !== 4'b0000) begin errors++; $display("FAIL rmw_ack: got %b want 0000", port_ack); end
    checks++; if (port_data !== '0) begin errors++; $display("FAIL rmw_data: got %h want 0", port_data); end
    checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL rmw_sdr_req: got %b want 0", sdr_req); end
    checks++; if (sdr_address !== '0) begin errors++; $display("FAIL rmw_sdr_addr: got %h want 0", sdr_address); end
    reset = 1'b0;
    repeat (5) tick();
    checks++; if (port_ack !== 4'b0000) begin errors++; $display("FAIL rmw_no_ack: got %b want 0000", port_ack); end
    port_addr[0*AW +: AW] = 27'h0000060;
    port_req[0] = 1'b1;
    tick();
    checks++; if (sdr_req !== 1'b1) begin errors++; $display("FAIL rmw_idle_issue: got %b want 1", sdr_req); end
    checks++; if (sdr_address !== 27'h0000060) begin errors++; $display("FAIL rmw_idle_addr: got %h want 0000060", sdr_address); end
    sdr_data = 16'h6666;
    sdr_ack  = sdr_req;
    tick();
    checks++; if (port_ack !== 4'b0001) begin errors++; $display("FAIL rmw_after_ack: got %b want 0001", port_ack); end
    checks++; if (port_data[15:0] !== 16'h6666) begin errors++; $display("FAIL rmw_after_data: got %h want 6666", port_data[15:0]); end
  endtask

  task automatic test_wrap();
    bit seen;
    seen = 1'b0;
    addr3[2*AW +: AW] = 27'h0000100;
    req3[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack3 !== 3'b000) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen || ack3 !== 3'b100) begin errors++; $display("FAIL wrap_first_ack: got %b want 100", ack3); end
    checks++; if (data3[32 +: 16] !== 16'h0080) begin errors++; $display("FAIL wrap_first_data: got %h want 0080", data3[32 +: 16]); end
    addr3[0*AW +: AW] = 27'h0000200;
    addr3[2*AW +: AW] = 27'h0000300;
    req3 = req3 ^ 3'b101;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack3 !== 3'b100) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen || ack3 !== 3'b101) begin errors++; $display("FAIL wrap_order: got %b want 101", ack3); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack3 === 3'b001) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL wrap_second_ack: got %b want 001", ack3); end
    checks++; if (data3[15:0] !== 16'h0100) begin errors++; $display("FAIL wrap_p0_data: got %h want 0100", data3[15:0]); end
    checks++; if (data3[32 +: 16] !== 16'h0180) begin errors++; $display("FAIL wrap_p2_data: got %h want 0180", data3[32 +: 16]); end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    port_req  = '0;
    port_addr = '0;
    sdr_ack   = 1'b0;
    sdr_data  = '0;
    req3      = '0;
    addr3     = '0;
    test_reset();
    test_single_miss();
    test_hit();
    test_flush();
    test_round_robin();
    test_flush_in_wait();
    test_reset_mid_wait();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/audio_rom_arbiter.md
# audio_rom_arbiter

Shares the single SDRAM ROM read port between multiple sound-side fetch requesters (ADPCM-A, ADPCM-B, Z80 program ROM, spare) on Taito F2 boards. Each requester uses the same toggle req/ack handshake as the SDRAM port. A round-robin grant serialises fetches. A one-word per-port hit register answers repeat reads of the same 16-bit word without touching SDRAM.

## Interface
- NUM_PORTS, 4: number of requester ports, 2..8.
- ADDR_W, 27: SDRAM byte-address width.

- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  clears all hit registers; held high during ROM download.
- port_req  in  NUM_PORTS  per-port request toggle; port i has a request pending while port_req[i] != port_ack[i].
- port_addr  in  NUM_PORTS*ADDR_W  flattened byte addresses, port i at [i*ADDR_W +: ADDR_W]; held stable while pending.
- port_ack  out  NUM_PORTS  per-port ack toggle.
- port_data  out  NUM_PORTS*16  flattened returned word, port i at [i*16 +: 16]; valid from the ack toggle until the next ack on that port.
- sdr_address  out  ADDR_W  SDRAM word-aligned byte address, bit 0 always 0.
- sdr_req  out  1  SDRAM request toggle.
- sdr_ack  in  1  SDRAM ack toggle; the transaction is complete when sdr_ack == sdr_req.
- sdr_data  in  16  SDRAM read word; valid when sdr_ack == sdr_req.

## Operation
- State: IDLE, WAIT. Registers:
  - rr_ptr: next port to consider.
  - grant: index of the port being served.
  - hit_valid[i] and hit_addr[i]: word address bits [ADDR_W-1:1] per port.
- pending[i] = port_req[i] ^ port_ack[i].
- IDLE:
  - Scan pending from rr_ptr upward, modulo NUM_PORTS, and pick the first set port g.
  - If none is pending, stay in IDLE.
  - Hit: hit_valid[g] and hit_addr[g] == port_addr_g[ADDR_W-1:1], with flush low.
    - Toggle port_ack[g]. port_data[g] is unchanged.
    - rr_ptr <= g+1 (mod NUM_PORTS). Stay in IDLE.
  - Miss:
    - sdr_address <= {port_addr_g[ADDR_W-1:1],1'b0}.
    - sdr_req <= ~sdr_req; grant <= g; go to WAIT.
- WAIT, when sdr_ack == sdr_req:
  - port_data[grant] <= sdr_data; toggle port_ack[grant].
  - hit_addr[grant] <= sdr_address[ADDR_W-1:1].
  - hit_valid[grant] <= ~flush.
  - rr_ptr <= grant+1 (mod NUM_PORTS); go to IDLE.
- WAIT ignores new requests. They stay pending and are arbitrated on return to IDLE.
- flush high: clears every hit_valid each cycle. It does not abort an SDRAM transaction in flight; that data is still delivered to its port.
- rr_ptr wrap: NUM_PORTS-1 wraps to 0, including non-power-of-2 NUM_PORTS.
- Byte selection is done by the requester from its own address bit 0. The arbiter always returns the full word.
- Requester rule: a port must not toggle port_req again while pending. Such a toggle cancels the pending request and is not detected.

## Timing
- Reset values:
  - All port_ack and port_data bits 0; sdr_req 0; sdr_address 0.
  - hit_valid all 0; rr_ptr 0; grant 0; state IDLE.
- Reset mid-WAIT:
  - Abandons the transaction; no port ack is issued.
  - The SDRAM controller shares this reset, so sdr_req=0 stays consistent with its ack.
- Hit latency: port_req toggle sampled at edge N, port in IDLE and granted → port_ack toggles at edge N+1.
- Miss latency: sdr_req toggles at edge N+1. Completion is detected at the first edge M where sdr_ack == sdr_req; port_ack and port_data update at M. The next grant is evaluated at edge M+1.
- At most one SDRAM transaction is outstanding. At most one port is acked per cycle.
- Simultaneous pending ports are served in rr order, one per IDLE visit. Hits and misses share the same rotation.
- flush and a hit in the same cycle: flush wins and the request is issued to SDRAM as a miss.

## Test plan
- Single miss:
  - Stimulus: port 1 toggles req with addr 0x0100003; SDRAM acks after 5 cycles with 0xBEEF.
  - Required: sdr_address=0x0100002; port_ack[1] toggles with port_data[1]=0xBEEF.
  - Required: other ports' ack/data unchanged.
- Hit:
  - Stimulus: port 1 then requests addr 0x0100002.
  - Required: port_ack[1] toggles 1 cycle after the request, sdr_req does not toggle, data still 0xBEEF.
- Round robin:
  - Stimulus: ports 0, 2 and 3 all miss, toggled in the same cycle, with rr_ptr=2.
  - Required: SDRAM service order 2, 3, 0; exactly 3 sdr_req toggles.
- Flush:
  - Stimulus: flush pulsed for 1 cycle after the hit case, then port 1 re-requests 0x0100002.
  - Required: new sdr_req toggle and new sdr_data delivered.
  - Stimulus: flush high during WAIT.
  - Required: that data is delivered, and the next same-address request misses.
- Reset mid-transaction:
  - Stimulus: reset asserted while in WAIT.
  - Required: next cycle all outputs are 0 and state is IDLE; no port_ack toggles for the abandoned request.
- Wrap:
  - Stimulus: NUM_PORTS=3; port 2 served, then ports 0 and 2 pending.
  - Required: port 0 is served first.
